v5_trap_filter: RTL and testbench
=================================

Name: v5_trap_filter

Overview:
Next-generation trapezoidal shaper for the ADC chain. It keeps the same D/P/R/S recursion as the fixed-parameter filter, with these additions:
- K, L and M are programmable at run time through a load handshake, with validation.
- The pipeline advances only on valid samples, and output is blanked until settled.
- An integrated threshold peak detector reports each pulse amplitude.
- It sits between the ADC sample register and the event builder.

Parameters:
DATA_W, 14, signed ADC sample width
OUT_W, 16, signed output_data / peak_data width
ACC_W, 40, internal signed accumulator width (P, R, S)
DEPTH_MAX, 64, maximum K+L; delay line holds DEPTH_MAX+1 samples
KL_W, 7, width of cfg_k / cfg_l
M_W, 12, unsigned width of cfg_m
SHIFT, 4, arithmetic right shift applied to S to form output

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
input_data  in  DATA_W  signed ADC sample
in_valid  in  1  sample strobe; pipeline clock-enable
cfg_k  in  KL_W  rise length K
cfg_l  in  KL_W  L (flat top = L-K)
cfg_m  in  M_W  pole-zero constant M
cfg_load  in  1  one-cycle request to apply cfg_*
cfg_busy  out  1  high while settling after reset or load
cfg_err  out  1  one-cycle pulse: configuration rejected
threshold  in  OUT_W  signed peak-detector threshold
output_data  out  OUT_W  signed shaped output
out_valid  out  1  output_data updated and settled this cycle
peak_data  out  OUT_W  maximum output_data of the last pulse
peak_valid  out  1  one-cycle pulse with peak_data

Behaviour:
- Reset (reset=0, async):
  - All delay-line entries, D1, D2, D, P, Md, R, S, output_data, peak_data, out_valid, peak_valid and cfg_err clear to 0.
  - Active config becomes K=2, L=4, M=0.
  - cfg_busy=1 and the settle counter is loaded.
- Pipeline, advancing only on cycles with in_valid=1:
  - V[0]<=input_data; V[i]<=V[i-1].
  - D1<=V[0]-V[K]; D2<=V[L]-V[K+L]. Taps are selected by mux from the active K and L.
  - D<=D1-D2.
  - P<=P+D; Md<=M*D. Both come from the same D, so they stay aligned.
  - R<=P+Md.
  - S<=S+R.
  - output_data<=S>>>SHIFT, truncated to OUT_W.
  - Latency: a sample accepted on valid cycle n first affects output_data on valid cycle n+6.
  - When in_valid=0 every register holds its value.
- Arithmetic: all operations are signed in ACC_W. M is zero-extended before multiplying. Wraps modulo 2^ACC_W.
- Configuration handshake:
  - cfg_load is sampled every cycle.
  - Accepted only if 1<=cfg_k<=cfg_l and cfg_k+cfg_l<=DEPTH_MAX. On acceptance:
    - Latch K, L, M.
    - Clear D1, D2, D, P, Md, R, S and output_data. The delay line is kept.
    - Set cfg_busy=1 and reload the settle counter.
  - Rejected otherwise: cfg_err pulses for 1 cycle and the old config and state are untouched.
  - cfg_load while cfg_busy=1 is legal; on acceptance it restarts settling.
  - cfg_load coinciding with in_valid: the load wins, and that sample is still shifted into V[0].
- Settle FSM, states SETTLE and RUN:
  - SETTLE: counter = K+L+7 and decrements on each in_valid. When it reaches 0, go to RUN and set cfg_busy=0.
  - RUN: out_valid = in_valid delayed to align with the output_data update.
  - out_valid=0 while in SETTLE.
- Peak FSM, states ARMED and TRACK; evaluated only on out_valid cycles:
  - ARMED: when output_data>threshold, go to TRACK with peak_reg=output_data.
  - TRACK: peak_reg=max(peak_reg, output_data). When output_data<=threshold, output peak_data=peak_reg, pulse peak_valid for 1 cycle and return to ARMED.
  - Entering SETTLE (reset or accepted load) forces ARMED with no peak_valid, abandoning any open pulse.

Optional Feature:
TRAP_SAT_EN.
- Defined: output_data saturates to the OUT_W signed range, i.e. +2^(OUT_W-1)-1 or -2^(OUT_W-1), when S>>>SHIFT overflows.
- Undefined: plain truncation to the low OUT_W bits.
- The peak detector sees the post-saturation value in both cases.

Test Plan:
1. Reset during streaming, then release → all outputs 0, cfg_busy=1, out_valid=0 for exactly K+L+7=13 valid samples, then out_valid follows in_valid.
2. Load K=4, L=8, M=0, SHIFT=0 build; impulse input_data=100 for one sample, then zeros → output_data runs 100, 200, 300, 400, then 400 for 4 samples, then 300, 200, 100, 0. First nonzero appears 6 valid cycles after the impulse.
3. Same impulse with threshold=250 → exactly one peak_valid, with peak_data=400, on the cycle output_data drops to 200.
4. cfg_load with K=10, L=5, then K=40, L=40 (DEPTH_MAX=64) → two cfg_err pulses; the previous config still gives the step-2 response.
5. in_valid toggling 1,0,0,1 around the step-2 impulse → identical output_data sequence on out_valid cycles; values hold while in_valid=0.
6. With TRAP_SAT_EN, OUT_W=16, impulse of +8191 with K=8 → output_data clamps at 32767 and never wraps negative. Without it, the wrapped value is observed.

Source files
------------

// File: rtl/v5_trap_filter.sv
// v5_trap_filter: trapezoidal shaper, run-time K/L/M, settle gating, peak detect.
// Define TRAP_SAT_EN to saturate output_data instead of wrapping it.
module v5_trap_filter #(
  parameter int DATA_W    = 14,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 40,
  parameter int DEPTH_MAX = 64,
  parameter int KL_W      = 7,
  parameter int M_W       = 12,
  parameter int SHIFT     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic                     in_valid,
  input  logic        [KL_W-1:0]   cfg_k,
  input  logic        [KL_W-1:0]   cfg_l,
  input  logic        [M_W-1:0]    cfg_m,
  input  logic                     cfg_load,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  input  logic signed [OUT_W-1:0]  threshold,
  output logic signed [OUT_W-1:0]  output_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  peak_data,
  output logic                     peak_valid
);
  localparam int IW = $clog2(DEPTH_MAX + 1);
  localparam int CW = 8;
  localparam logic [KL_W:0] KL_MAX = (KL_W+1)'(DEPTH_MAX);
  localparam logic [CW-1:0] CNT_RST = CW'(2 + 4 + 7);

  typedef enum logic {SETTLE, RUN} settle_t;
  typedef enum logic {ARMED, TRACK} peak_t;

  logic signed [DATA_W-1:0] v [DEPTH_MAX+1];
  logic [KL_W-1:0] k, l;
  logic [M_W-1:0]  m;
  logic [KL_W:0]   kl, cfg_sum;
  logic            cfg_ok, load_ok;

  logic signed [ACC_W-1:0] v0, vk, vl, vkl, m_ext;
  logic signed [ACC_W-1:0] d1, d2, d, p, md, r, s;
  logic signed [OUT_W-1:0] out_n;

  settle_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ov_n;

  peak_t pk, pk_n;
  logic signed [OUT_W-1:0] pr, pr_n, pd_n;
  logic pv_n;

  assign kl      = {1'b0, k} + {1'b0, l};
  assign cfg_sum = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok  = (cfg_k != '0) && (cfg_k <= cfg_l)
                && (cfg_sum <= KL_MAX);
  assign load_ok = cfg_load && cfg_ok;

  assign v0    = ACC_W'(v[0]);
  assign vk    = ACC_W'(v[IW'(k)]);
  assign vl    = ACC_W'(v[IW'(l)]);
  assign vkl   = ACC_W'(v[IW'(kl)]);
  assign m_ext = ACC_W'(m);

  assign cfg_busy = (st == SETTLE);

`ifdef TRAP_SAT_EN
  localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
  logic signed [ACC_W-1:0] sh;
  logic fits;
  assign sh   = s >>> SHIFT;
  assign fits = (&sh[ACC_W-1:OUT_W-1]) || ~(|sh[ACC_W-1:OUT_W-1]);
  always_comb begin
    out_n = sh[OUT_W-1:0];
    if (!fits) out_n = sh[ACC_W-1] ? OMIN : OMAX;
  end
`else
  assign out_n = s[SHIFT+OUT_W-1:SHIFT];
`endif

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    if (load_ok) begin
      st_n  = SETTLE;
      cnt_n = CW'(cfg_sum) + CW'(7);
    end else if (st == SETTLE && in_valid) begin
      cnt_n = cnt - CW'(1);
      if (cnt == CW'(1)) st_n = RUN;
    end
  end

  assign ov_n = in_valid && (st == RUN) && !load_ok;

  // Peak decision uses the value output_data takes at this same edge
  always_comb begin
    pk_n = pk;
    pr_n = pr;
    pd_n = peak_data;
    pv_n = 1'b0;
    if (load_ok) begin
      pk_n = ARMED;
    end else if (ov_n) begin
      unique case (pk)
        ARMED: begin
          if (out_n > threshold) begin
            pk_n = TRACK;
            pr_n = out_n;
          end
        end
        TRACK: begin
          if (out_n > threshold) begin
            if (out_n > pr) pr_n = out_n;
          end else begin
            pd_n = pr;
            pv_n = 1'b1;
            pk_n = ARMED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st  <= SETTLE;
      cnt <= CNT_RST;
      pk  <= ARMED;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
      pk  <= pk_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= DEPTH_MAX; i++) v[i] <= '0;
      k           <= KL_W'(2);
      l           <= KL_W'(4);
      m           <= '0;
      d1          <= '0;
      d2          <= '0;
      d           <= '0;
      p           <= '0;
      md          <= '0;
      r           <= '0;
      s           <= '0;
      output_data <= '0;
      out_valid   <= 1'b0;
      cfg_err     <= 1'b0;
      peak_data   <= '0;
      peak_valid  <= 1'b0;
      pr          <= '0;
    end else begin
      cfg_err    <= cfg_load && !cfg_ok;
      out_valid  <= ov_n;
      peak_valid <= pv_n;
      peak_data  <= pd_n;
      pr         <= pr_n;
      if (in_valid) begin
        v[0] <= input_data;
        for (int i = 1; i <= DEPTH_MAX; i++) v[i] <= v[i-1];
      end
      if (load_ok) begin
        k           <= cfg_k;
        l           <= cfg_l;
        m           <= cfg_m;
        d1          <= '0;
        d2          <= '0;
        d           <= '0;
        p           <= '0;
        md          <= '0;
        r           <= '0;
        s           <= '0;
        output_data <= '0;
      end else if (in_valid) begin
        d1          <= v0 - vk;
        d2          <= vl - vkl;
        d           <= d1 - d2;
        p           <= p + d;
        md          <= d * m_ext;
        r           <= p + md;
        s           <= s + r;
        output_data <= out_n;
      end
    end
  end
endmodule

// File: tb/tb_v5_trap_filter.sv
// tb_v5_trap_filter: random and directed stimulus against a
// sample-history model of the trapezoid shaper and peak detector.
module tb_v5_trap_filter;
  localparam int DATA_W = 14, OUT_W = 16, ACC_W = 40;
  localparam int DEPTH_MAX = 64, KL_W = 7, M_W = 12, SHIFT = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [DATA_W-1:0] input_data = '0;
  logic in_valid = 1'b0;
  logic [KL_W-1:0] cfg_k = '0, cfg_l = '0;
  logic [M_W-1:0] cfg_m = '0;
  logic cfg_load = 1'b0;
  logic cfg_busy, cfg_err, out_valid, peak_valid;
  logic signed [OUT_W-1:0] threshold = '0;
  logic signed [OUT_W-1:0] output_data, peak_data;

  v5_trap_filter #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .ACC_W(ACC_W),
    .DEPTH_MAX(DEPTH_MAX), .KL_W(KL_W), .M_W(M_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data),
    .in_valid(in_valid), .cfg_k(cfg_k), .cfg_l(cfg_l),
    .cfg_m(cfg_m), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .threshold(threshold),
    .output_data(output_data), .out_valid(out_valid),
    .peak_data(peak_data), .peak_valid(peak_valid)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int mk, ml, mm, nv, mpk;
  longint hist[$], sv[$], mp, ms;
  logic signed [OUT_W-1:0] exp_out, exp_pd, mpr, thr, vmax, vmin;
  logic exp_ov, exp_busy, exp_err, exp_pv;
  int exp_seq[18] = '{0, 0, 0, 0, 0, 0, 100, 200, 300,
                      400, 400, 400, 400, 400, 300, 200, 100, 0};

  function automatic longint w40(longint x);
    logic signed [ACC_W-1:0] t;
    t = x[ACC_W-1:0];
    return longint'(t);
  endfunction

  function automatic logic signed [OUT_W-1:0] fmt(longint x);
    longint sh, hi, lo;
    logic signed [OUT_W-1:0] t;
    sh = x >>> SHIFT;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = -(longint'(1) <<< (OUT_W-1));
    t = sh[OUT_W-1:0];
`ifdef TRAP_SAT_EN
    if (sh > hi) t = hi[OUT_W-1:0];
    else if (sh < lo) t = lo[OUT_W-1:0];
`endif
    return t;
  endfunction

  function automatic longint xh(int i);
    return (i >= 0) ? hist[i] : 0;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 16383)) - 8192;
  endfunction

  task automatic model_restart(input int k, input int l, input int m);
    mk = k; ml = l; mm = m;
    hist.delete(); sv.delete();
    mp = 0; ms = 0; nv = 0; mpk = 0;
    exp_out = '0; exp_ov = 1'b0; exp_busy = 1'b1; exp_pv = 1'b0;
  endtask

  task automatic cycle(input bit v, input int x, input bit ld,
                       input int k, input int l, input int m);
    bit ok;
    int j;
    longint d;
    in_valid = v; input_data = DATA_W'(x);
    cfg_load = ld; cfg_k = KL_W'(k); cfg_l = KL_W'(l);
    cfg_m = M_W'(m); threshold = thr;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    ok = ld && k >= 1 && k <= l && k + l <= DEPTH_MAX;
    exp_err = ld && !ok;
    exp_pv = 1'b0;
    if (ok) begin
      model_restart(k, l, m);
    end else begin
      exp_ov = v && (nv >= mk + ml + 7);
      if (v) begin
        j = hist.size();
        hist.push_back(longint'(x));
        d = xh(j) - xh(j - mk) - xh(j - ml) + xh(j - mk - ml);
        mp = w40(mp + d);
        ms = w40(ms + mp + longint'(mm) * d);
        sv.push_back(ms);
        exp_out = (j >= 6) ? fmt(sv[j-6]) : '0;
        nv++;
      end
      exp_busy = (nv < mk + ml + 7);
      if (exp_ov) begin
        if (mpk == 0) begin
          if (exp_out > thr) begin mpk = 1; mpr = exp_out; end
        end else if (exp_out > thr) begin
          if (exp_out > mpr) mpr = exp_out;
        end else begin
          exp_pv = 1'b1; exp_pd = mpr; mpk = 0;
        end
      end
    end
  endtask

  task automatic step(input bit v, input int x);
    cycle(v, x, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int blank;
    bit seen, v;
    thr = 16'sd5000;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), rnd());
    @(posedge clk); #3 reset = 1'b0; #1;
    checks += 3;
    if (output_data !== '0 || peak_data !== '0) begin
      errors++;
      $display("FAIL reset_data out=%0d peak=%0d want 0 0", output_data, peak_data);
    end
    if (out_valid !== 1'b0 || peak_valid !== 1'b0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags ov=%b pv=%b err=%b want 0 0 0", out_valid, peak_valid, cfg_err);
    end
    if (cfg_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy got %b want 1", cfg_busy);
    end
    model_restart(2, 4, 0);
    exp_pd = '0;
    @(posedge clk); #1 reset = 1'b1;
    blank = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(0, 3) != 0);
      step(v, rnd());
      checks += 5;
      if (out_valid !== exp_ov) begin errors++; $display("FAIL rst_ov cyc %0d got %b want %b", i, out_valid, exp_ov); end
      if (output_data !== exp_out) begin errors++; $display("FAIL rst_out cyc %0d got %0d want %0d", i, output_data, exp_out); end
      if (cfg_busy !== exp_busy) begin errors++; $display("FAIL rst_busy cyc %0d got %b want %b", i, cfg_busy, exp_busy); end
      if (cfg_err !== exp_err) begin errors++; $display("FAIL rst_err cyc %0d got %b want %b", i, cfg_err, exp_err); end
      if (peak_valid !== exp_pv || (exp_pv && peak_data !== exp_pd)) begin errors++; $display("FAIL rst_peak cyc %0d got %b/%0d want %b/%0d", i, peak_valid, peak_data, exp_pv, exp_pd); end
      if (out_valid) seen = 1'b1;
      else if (v && !seen) blank++;
    end
    checks++;
    if (blank != 13) begin
      errors++;
      $display("FAIL settle_len got %0d want 13", blank);
    end
  endtask

  task automatic test_impulse(input bit gaps, input int t, input bit reload,
                              input int k, input int l, input int amp);
    logic signed [OUT_W-1:0] got[$];
    logic signed [OUT_W-1:0] pkd, out_at_pk;
    int npk, nvs;
    bit v;
    thr = OUT_W'(t);
    if (reload) begin
      for (int i = 0; i < 80; i++) step(1'b1, 0);
      cycle(1'b0, 0, 1'b1, k, l, 0);
    end
    for (int i = 0; i < k + l + 8; i++) step(1'b1, 0);
    npk = 0; nvs = 0; pkd = '0; out_at_pk = '0;
    vmax = 16'sh8000; vmin = 16'sh7fff;
    for (int i = 0; i < 200 && nvs < 30; i++) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      step(v, v ? ((nvs == 0) ? amp : 0) : rnd());
      checks += 4;
      if (out_valid !== exp_ov) begin errors++; $display("FAIL imp_ov cyc %0d got %b want %b", i, out_valid, exp_ov); end
      if (output_data !== exp_out) begin errors++; $display("FAIL imp_out cyc %0d got %0d want %0d", i, output_data, exp_out); end
      if (cfg_busy !== exp_busy) begin errors++; $display("FAIL imp_busy cyc %0d got %b want %b", i, cfg_busy, exp_busy); end
      if (peak_valid !== exp_pv || (exp_pv && peak_data !== exp_pd)) begin errors++; $display("FAIL imp_peak cyc %0d got %b/%0d want %b/%0d", i, peak_valid, peak_data, exp_pv, exp_pd); end
      if (peak_valid) begin npk++; pkd = peak_data; out_at_pk = output_data; end
      if (v) begin
        got.push_back(output_data);
        if (output_data > vmax) vmax = output_data;
        if (output_data < vmin) vmin = output_data;
        nvs++;
      end
    end
    if (amp == 100 && k == 4 && l == 8) begin
      checks++;
      if (got.size() < 18) begin
        errors++;
        $display("FAIL imp_len got %0d want 18", got.size());
      end else begin
        for (int i = 0; i < 18; i++) begin
          checks++;
          if (got[i] !== OUT_W'(exp_seq[i])) begin errors++; $display("FAIL imp_seq idx %0d got %0d want %0d", i, got[i], exp_seq[i]); end
        end
      end
    end
    if (t == 250) begin
      checks++;
      if (npk != 1 || pkd !== 16'sd400 || out_at_pk !== 16'sd200) begin
        errors++;
        $display("FAIL imp_peaks n=%0d data=%0d out=%0d want 1 400 200", npk, pkd, out_at_pk);
      end
    end
  endtask

  task automatic test_cfg_err();
    int kb[3] = '{10, 40, 0};
    int lb[3] = '{5, 40, 3};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b1, kb[i], lb[i], 77);
      checks++;
      if (cfg_err !== 1'b1 || cfg_busy !== 1'b0) begin errors++; $display("FAIL cfg_rej %0d err=%b busy=%b want 1 0", i, cfg_err, cfg_busy); end
      step(1'b0, 0);
      checks++;
      if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_pulse %0d got %b want 0", i, cfg_err); end
    end
    test_impulse(1'b0, 250, 1'b0, 4, 8, 100);
  endtask

  task automatic test_sat();
    test_impulse(1'b0, 32767, 1'b1, 8, 8, 8191);
    checks++;
`ifdef TRAP_SAT_EN
    if (vmax !== 16'sd32767 || vmin < 0) begin errors++; $display("FAIL sat_clamp max=%0d min=%0d want 32767 >=0", vmax, vmin); end
`else
    if (vmin >= 0) begin errors++; $display("FAIL sat_wrap min=%0d want negative", vmin); end
`endif
  endtask

  task automatic test_random();
    int k, l, m;
    bit v;
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(1, 32);
      l = $urandom_range(k, DEPTH_MAX - k);
      m = $urandom_range(0, 4095);
      thr = OUT_W'($urandom_range(0, 20000));
      for (int i = 0; i < 80; i++) step(1'b1, 0);
      cycle(1'b0, 0, 1'b1, k, l, m);
      for (int i = 0; i < 200; i++) begin
        v = ($urandom_range(0, 3) != 0);
        if (i == 100) cycle(v, rnd(), 1'b1, 0, 5, 7);
        else step(v, rnd());
        checks += 5;
        if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_ov it %0d cyc %0d got %b want %b", it, i, out_valid, exp_ov); end
        if (output_data !== exp_out) begin errors++; $display("FAIL rnd_out it %0d cyc %0d got %0d want %0d", it, i, output_data, exp_out); end
        if (cfg_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy it %0d cyc %0d got %b want %b", it, i, cfg_busy, exp_busy); end
        if (cfg_err !== exp_err) begin errors++; $display("FAIL rnd_err it %0d cyc %0d got %b want %b", it, i, cfg_err, exp_err); end
        if (peak_valid !== exp_pv || (exp_pv && peak_data !== exp_pd)) begin errors++; $display("FAIL rnd_peak it %0d cyc %0d got %b/%0d want %b/%0d", it, i, peak_valid, peak_data, exp_pv, exp_pd); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse(1'b0, 32767, 1'b1, 4, 8, 100);
    test_impulse(1'b0, 250, 1'b0, 4, 8, 100);
    test_impulse(1'b1, 32767, 1'b0, 4, 8, 100);
    test_cfg_err();
    test_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
